// File: rtl/wb_spram_pkg.sv
// Shared types for the Wishbone single-port SRAM controller.
package wb_spram_pkg;

  typedef enum logic {
    SCRUB = 1'b0,
    RUN   = 1'b1
  } state_e;

  typedef struct packed {
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } wb_req_t;

  // Address travels separately because its width depends on the RAM size.
  typedef struct packed {
    logic        ce;
    logic [3:0]  we;
    logic [31:0] d;
  } sram_port_t;

  localparam logic [3:0] ALL_LANES = 4'hF;

  // Full 32-bit compare so aliased high addresses are rejected, not wrapped.
  function automatic logic addr_in_range(logic [31:0] adr, logic [31:0] lim);
    return adr < lim;
  endfunction

endpackage

// File: rtl/wb_spram_ctrl.sv
// Wishbone B4 pipelined slave in front of an external single-port SRAM.
// Optionally zero-fills the SRAM after reset before accepting traffic.
//
//  state | meaning
//  SCRUB | writing zero to word scrub counter, bus stalled
//  RUN   | bus operational, one request per cycle
module wb_spram_ctrl
  import wb_spram_pkg::*;
#(
  parameter int unsigned size       = 'h80,
  parameter int unsigned addr_width = $clog2(size) - 2,
  parameter bit          scrub_en   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_cyc,
  input  logic                  wb_stb,
  input  logic                  wb_we,
  input  logic [31:0]           wb_adr,
  input  logic [3:0]            wb_sel,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack,
  output logic                  wb_err,
  output logic                  wb_stall,
  output logic [addr_width-1:0] ram_addr,
  output logic                  ram_ce,
  output logic [3:0]            ram_we,
  output logic [31:0]           ram_d,
  input  logic [31:0]           ram_q,
  output logic                  scrub_done
);

  localparam logic [31:0]           SizeBytes  = 32'(size);
  localparam logic [addr_width-1:0] LastWord   = '1;
  localparam state_e                ResetState = scrub_en ? SCRUB : RUN;

  state_e                state_q, state_d;
  logic [addr_width-1:0] cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  wb_req_t               req;
  sram_port_t            port;
  logic                  accept;
  logic                  in_range;

  assign req = '{cyc: wb_cyc, stb: wb_stb, we: wb_we, adr: wb_adr,
                 sel: wb_sel, dat: wb_dat_i};

  assign accept   = (state_q == RUN) && req.cyc && req.stb;
  assign in_range = addr_in_range(req.adr, SizeBytes);

  // Next state, scrub counter, response flags and SRAM port drive.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    port     = '0;
    ram_addr = '0;
    case (state_q)
      SCRUB: begin
        port.ce  = 1'b1;
        port.we  = ALL_LANES;
        port.d   = '0;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + addr_width'(1);
        if (cnt_q == LastWord) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (in_range) begin
            port.ce  = 1'b1;
            port.we  = req.we ? req.sel : 4'h0;
            port.d   = req.dat;
            ram_addr = req.adr[addr_width+1:2];
            ack_d    = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ResetState;
    endcase
  end

  // State, scrub counter and one-cycle-delayed responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // A master that drops cyc abandons any response still in flight.
  assign wb_ack     = ack_q & wb_cyc;
  assign wb_err     = err_q & wb_cyc;
  assign wb_dat_o   = ram_q;
  assign wb_stall   = (state_q == SCRUB);
  assign scrub_done = (state_q == RUN);
  assign ram_ce     = port.ce;
  assign ram_we     = port.we;
  assign ram_d      = port.d;

endmodule

// File: tb/tb_wb_spram_ctrl.sv
// Bench for wb_spram_ctrl: SRAM wrapper model, behavioural reference,
// directed scenarios and a randomized traffic phase.
module tb_wb_spram_ctrl;

  localparam int SIZE  = 'h80;
  localparam int WORDS = SIZE / 4;
  localparam int AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [31:0]   wb_adr = '0;
  logic [3:0]    wb_sel = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack, wb_err, wb_stall;
  logic [AW-1:0] ram_addr;
  logic          ram_ce;
  logic [3:0]    ram_we;
  logic [31:0]   ram_d;
  logic [31:0]   ram_q = '0;
  logic          scrub_done;

  wb_spram_ctrl #(.size(SIZE), .addr_width(AW), .scrub_en(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_sel(wb_sel), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack(wb_ack), .wb_err(wb_err), .wb_stall(wb_stall),
    .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_d(ram_d),
    .ram_q(ram_q), .scrub_done(scrub_done)
  );

  always #5 clk = ~clk;

  // SRAM wrapper: byte-writable, registered read of the pre-write contents.
  logic [31:0] mem [WORDS];
  always @(posedge clk) begin
    if (ram_ce) begin
      ram_q <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, scrub words remaining, one pending response.
  logic [31:0] ref_mem [WORDS];
  int          scrub_left = WORDS;
  bit          pend_ack = 0, pend_err = 0, pend_rd = 0;
  logic [31:0] pend_data = '0;
  int          ack_cnt = 0, err_cnt = 0;
  logic [31:0] last_rd = '0;
  logic        last_ce = 1'b0;

  // Compare process: outputs are checked 1 ns after each falling edge.
  always @(negedge clk) begin
    int          w;
    logic [4:0]  idx;
    bit          acc, inr;
    #1;
    if (!rst_n) begin
      scrub_left = WORDS;
      pend_ack   = 0;
      pend_err   = 0;
      chk("rst_stall", wb_stall, 1);
      chk("rst_ack", wb_ack, 0);
      chk("rst_err", wb_err, 0);
      chk("rst_done", scrub_done, 0);
    end else begin
      chk("ack", wb_ack, pend_ack && wb_cyc);
      chk("err", wb_err, pend_err && wb_cyc);
      if (pend_ack && pend_rd && wb_cyc) begin
        chk("rdata", wb_dat_o, pend_data);
        last_rd = wb_dat_o;
      end
      if (wb_ack) ack_cnt++;
      if (wb_err) err_cnt++;
      chk("stall", wb_stall, scrub_left > 0);
      chk("scrub_done", scrub_done, scrub_left == 0);
      pend_ack = 0;
      pend_err = 0;
      if (scrub_left > 0) begin
        w = WORDS - scrub_left;
        chk("scrub_ce", ram_ce, 1);
        chk("scrub_we", ram_we, 4'hF);
        chk("scrub_d", ram_d, 0);
        chk("scrub_addr", ram_addr, w);
        ref_mem[w] = '0;
        scrub_left--;
      end else begin
        acc = wb_cyc && wb_stb;
        inr = wb_adr < SIZE;
        chk("ram_ce", ram_ce, acc && inr);
        if (acc && inr) begin
          idx = wb_adr[6:2];
          chk("ram_addr", ram_addr, idx);
          chk("ram_we", ram_we, wb_we ? wb_sel : 4'h0);
          chk("ram_d", ram_d, wb_dat_i);
          pend_ack  = 1;
          pend_rd   = !wb_we;
          pend_data = ref_mem[idx];
          if (wb_we)
            for (int b = 0; b < 4; b++)
              if (wb_sel[b]) ref_mem[idx][8*b +: 8] = wb_dat_i[8*b +: 8];
        end else if (acc) begin
          pend_err = 1;
        end
      end
    end
  end

  task automatic req(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
    #2 last_ce = ram_ce;
  endtask

  task automatic idle();
    @(negedge clk);
    wb_cyc = 1; wb_stb = 0; wb_we = 0;
    #2;
  endtask

  // Release reset and count stalled cycles until the bus opens.
  task automatic release_and_count(output int n);
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
    rst_n = 1;
    n = 0;
    #2;
    while (wb_stall && n < 100) begin
      n++;
      @(negedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a0, e0;
    for (int i = 0; i < WORDS; i++) begin
      mem[i]     = 32'hA5A5A5A5;
      ref_mem[i] = 32'hA5A5A5A5;
    end
    repeat (3) @(negedge clk);

    // Scrub after power-on reset.
    release_and_count(n);
    chk("scrub_len", n, 32);
    for (int i = 0; i < WORDS; i++) begin
      req(0, i * 4, 4'hF, 0);
      idle();
      chk("scrub_zero", last_rd, 0);
    end

    // Pipelined write then read.
    a0 = ack_cnt;
    req(1, 'h10, 4'hF, 32'h11223344);
    req(0, 'h10, 4'hF, 0);
    idle();
    chk("pipe_acks", ack_cnt - a0, 2);
    chk("pipe_rd", last_rd, 32'h11223344);

    // Byte lanes.
    req(1, 'h20, 4'hF, 32'hFFFFFFFF);
    req(1, 'h20, 4'b0001, 32'h000000AB);
    req(0, 'h20, 4'hF, 0);
    idle();
    chk("lane_rd", last_rd, 32'hFFFFFFAB);

    // sel=0 write is acked but changes nothing.
    a0 = ack_cnt;
    req(1, 'h24, 4'hF, 32'h12345678);
    req(1, 'h24, 4'h0, 32'hDEADBEEF);
    req(0, 'h24, 4'hF, 0);
    idle();
    chk("sel0_acks", ack_cnt - a0, 3);
    chk("sel0_rd", last_rd, 32'h12345678);

    // Out-of-range accesses.
    a0 = ack_cnt; e0 = err_cnt;
    req(0, 'h80, 4'hF, 0);
    chk("oor80_ce", last_ce, 0);
    req(0, 32'hFFFFFFFC, 4'hF, 0);
    chk("oorfc_ce", last_ce, 0);
    idle();
    chk("oor_errs", err_cnt - e0, 2);
    chk("oor_acks", ack_cnt - a0, 0);

    // Abandoned cycle.
    a0 = ack_cnt;
    req(0, 'h10, 4'hF, 0);
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0;
    idle();
    chk("abandon_acks", ack_cnt - a0, 0);

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      int r;
      @(negedge clk);
      wb_cyc   = ($urandom_range(0, 7) != 0);
      wb_stb   = ($urandom_range(0, 3) != 0);
      wb_we    = $urandom_range(0, 1);
      wb_sel   = 4'($urandom_range(0, 15));
      wb_dat_i = $urandom();
      r = $urandom_range(0, 9);
      if (r == 0)      wb_adr = $urandom();
      else if (r == 1) wb_adr = 32'h80 + 32'($urandom_range(0, 63));
      else             wb_adr = 32'($urandom_range(0, SIZE - 1));
    end
    idle();

    // Reset while a read ack is pending.
    req(0, 'h10, 4'hF, 0);
    @(posedge clk);
    #2 rst_n = 0;
    #1 chk("rst_drop_ack", wb_ack, 0);
    repeat (2) @(negedge clk);
    release_and_count(n);
    chk("rescrub_len", n, 32);

    // Reset in the middle of the scrub, at word 10.
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h5A5A5A5A;
    rst_n = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (10) @(negedge clk);
    #2 chk("scrub_w10", ram_addr, 10);
    rst_n = 0;
    repeat (3) @(negedge clk);
    release_and_count(n);
    chk("restart_len", n, 32);
    for (int i = 0; i < WORDS; i += 5) begin
      req(0, i * 4, 4'hF, 0);
      idle();
      chk("restart_zero", last_rd, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
